// File: rtl/burst_addr_seq.sv
// Serial burst address sequencer: loads a start address and burst length serially,
// then emits one ADDR_W-bit address frame per beat. Define BURST_WRAP_MODE_EN for wrapping bursts.
module burst_addr_seq #(
   parameter int ADDR_W    = 8,
   parameter int LEN_W     = 4,
   parameter int WRAP_LOG2 = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       burst_en,
   input  logic [1:0] mode_sel,
   input  logic       burst_len_in,
   input  logic       addr_in,
   output logic       addr_sel,
   output logic       addr_ser_out,
   output logic       busy,
   output logic       done
);

   localparam int CNT_W = $clog2(ADDR_W);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, NEXT, DONE} state_t;

   state_t            state;
   logic [1:0]        mode_r;
   logic [ADDR_W-1:0] addr_r;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  beats_r;
   logic [CNT_W-1:0]  bit_cnt;

   logic [ADDR_W-1:0] addr_ld, addr_inc, addr_nxt;
   logic [LEN_W-1:0]  len_ld, beats_ld;
   logic              last_bit, single_sel;

`ifdef BURST_WRAP_MODE_EN
   localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'((64'd1 << WRAP_LOG2) - 64'd1);
`endif

   always_comb begin
      addr_ld    = (addr_r << 1) | ADDR_W'(addr_in);
      // length only captures during the first LEN_W load cycles
      len_ld     = ({1'b0, bit_cnt} < (CNT_W+1)'(LEN_W)) ? ((len_r << 1) | LEN_W'(burst_len_in)) : len_r;
      single_sel = (mode_r == 2'b00) || (mode_r == 2'b11);
      beats_ld   = (single_sel || len_ld == '0) ? LEN_W'(1) : len_ld;
      addr_inc   = addr_r + ADDR_W'(1);
`ifdef BURST_WRAP_MODE_EN
      addr_nxt   = (mode_r == 2'b10) ? ((addr_r & ~WRAP_MASK) | (addr_inc & WRAP_MASK)) : addr_inc;
`else
      addr_nxt   = addr_inc;
`endif
      last_bit   = (bit_cnt == CNT_W'(ADDR_W-1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         mode_r       <= '0;
         addr_r       <= '0;
         len_r        <= '0;
         beats_r      <= '0;
         bit_cnt      <= '0;
         addr_sel     <= 1'b0;
         addr_ser_out <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else if (state != IDLE && !burst_en) begin
         // abort: drop everything, no done pulse
         state        <= IDLE;
         addr_r       <= '0;
         len_r        <= '0;
         beats_r      <= '0;
         bit_cnt      <= '0;
         addr_sel     <= 1'b0;
         addr_ser_out <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (burst_en) begin
                  mode_r  <= mode_sel;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               addr_r <= addr_ld;
               len_r  <= len_ld;
               if (last_bit) begin
                  bit_cnt      <= '0;
                  beats_r      <= beats_ld;
                  addr_sel     <= 1'b1;
                  addr_ser_out <= addr_ld[ADDR_W-1];
                  state        <= SHIFT;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            SHIFT: begin
               if (last_bit) begin
                  bit_cnt      <= '0;
                  addr_sel     <= 1'b0;
                  addr_ser_out <= 1'b0;
                  state        <= NEXT;
               end else begin
                  bit_cnt      <= bit_cnt + CNT_W'(1);
                  addr_ser_out <= addr_r[CNT_W'(ADDR_W-2) - bit_cnt];
               end
            end
            NEXT: begin
               addr_r  <= addr_nxt;
               beats_r <= beats_r - LEN_W'(1);
               if (beats_r > LEN_W'(1)) begin
                  addr_sel     <= 1'b1;
                  addr_ser_out <= addr_nxt[ADDR_W-1];
                  state        <= SHIFT;
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_burst_addr_seq.sv
// Directed bench for burst_addr_seq: table of bursts plus abort and reset sequences.
module tb_burst_addr_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       burst_en;
   logic [1:0] mode_sel;
   logic       burst_len_in;
   logic       addr_in;
   logic       addr_sel;
   logic       addr_ser_out;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   burst_addr_seq #(.ADDR_W(8), .LEN_W(4), .WRAP_LOG2(2)) dut (
      .clk(clk), .rst(rst), .burst_en(burst_en), .mode_sel(mode_sel),
      .burst_len_in(burst_len_in), .addr_in(addr_in), .addr_sel(addr_sel),
      .addr_ser_out(addr_ser_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string          name;
      logic [1:0]     mode;
      logic [7:0]     addr;
      logic [3:0]     len;
      int             nbeats;
      logic [3:0][7:0] fr;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_burst(input logic [1:0] mode, input logic [7:0] addr, input logic [3:0] len);
      burst_en = 1'b1;
      mode_sel = mode;
      tick();
      check("load_busy", busy, 1);
      mode_sel = ~mode;   // must be ignored once latched
      for (int i = 0; i < 8; i++) begin
         addr_in      = addr[7-i];
         burst_len_in = (i < 4) ? len[3-i] : 1'b0;
         check("load_sel", addr_sel, 0);
         tick();
      end
      addr_in = 1'b0;
      burst_len_in = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] frame;
      int sel_bad;
      load_burst(v.mode, v.addr, v.len);
      for (int b = 0; b < v.nbeats; b++) begin
         check({v.name, "_first_sel"}, addr_sel, 1);
         frame = '0;
         sel_bad = 0;
         for (int k = 0; k < 8; k++) begin
            frame = {frame[6:0], addr_ser_out};
            if (addr_sel !== 1'b1) sel_bad++;
            check({v.name, "_done_low"}, done, 0);
            tick();
         end
         check({v.name, "_frame"}, frame, v.fr[b]);
         check({v.name, "_sel_hold"}, sel_bad, 0);
         check({v.name, "_next_sel"}, {addr_sel, addr_ser_out}, 0);
         tick();
      end
      check({v.name, "_done"}, {done, busy, addr_sel}, 3'b110);
      tick();
      check({v.name, "_idle"}, {done, busy, addr_sel, addr_ser_out}, 0);
   endtask

   initial begin
      vecs[0] = '{"single",  2'b00, 8'hA5, 4'd3, 1, {8'h00, 8'h00, 8'h00, 8'hA5}};
      vecs[1] = '{"incr",    2'b01, 8'h3E, 4'd3, 3, {8'h00, 8'h40, 8'h3F, 8'h3E}};
      vecs[2] = '{"rollover",2'b01, 8'hFE, 4'd4, 4, {8'h01, 8'h00, 8'hFF, 8'hFE}};
`ifdef BURST_WRAP_MODE_EN
      vecs[3] = '{"wrap",    2'b10, 8'h16, 4'd4, 4, {8'h15, 8'h14, 8'h17, 8'h16}};
`else
      vecs[3] = '{"wrap",    2'b10, 8'h16, 4'd4, 4, {8'h19, 8'h18, 8'h17, 8'h16}};
`endif
      vecs[4] = '{"reserved",2'b11, 8'h80, 4'd2, 1, {8'h00, 8'h00, 8'h00, 8'h80}};
      vecs[5] = '{"len0",    2'b01, 8'h55, 4'd0, 1, {8'h00, 8'h00, 8'h00, 8'h55}};
      vecs[6] = '{"len0_rst",2'b01, 8'h7C, 4'd0, 1, {8'h00, 8'h00, 8'h00, 8'h7C}};

      rst = 1'b1; burst_en = 1'b0; mode_sel = 2'b00; burst_len_in = 1'b0; addr_in = 1'b0;
      #12;
      check("reset_outs", {addr_sel, addr_ser_out, busy, done}, 0);
      tick();
      rst = 1'b0;
      tick();
      check("idle_no_en", busy, 0);

      // back-to-back bursts: burst_en stays high through each single IDLE gap
      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // abort during beat 2 of a len-4 burst
      load_burst(2'b01, 8'h10, 4'd4);
      for (int k = 0; k < 9; k++) tick();
      check("abort_beat2_sel", addr_sel, 1);
      tick(); tick(); tick();
      burst_en = 1'b0;
      tick();
      check("abort_outs", {addr_sel, addr_ser_out, busy, done}, 0);
      for (int k = 0; k < 40; k++) begin
         if (done !== 1'b0 || busy !== 1'b0) check("abort_quiet", {busy, done}, 0);
         tick();
      end

      // asynchronous reset mid-SHIFT
      load_burst(2'b01, 8'hFF, 4'd2);
      tick(); tick();
      check("pre_rst_sel", {addr_sel, addr_ser_out, busy}, 3'b111);
      #2 rst = 1'b1;
      #1;
      check("rst_immediate", {addr_sel, addr_ser_out, busy, done}, 0);
      burst_en = 1'b0;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done !== 1'b0 || busy !== 1'b0) check("rst_no_done", {busy, done}, 0);
         tick();
      end
      run_vec(vecs[6]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/burst_addr_seq.md
BURST_ADDR_SEQ -- requirements
Module: burst_addr_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8: address width in bits, range 4..32.
REQ-002 The block SHALL have parameter LEN_W, default 4: burst-length field width in bits, LEN_W <= ADDR_W.
REQ-003 The block SHALL have parameter WRAP_LOG2, default 2: wrap-burst boundary is 2^WRAP_LOG2 beats, WRAP_LOG2 < ADDR_W.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port burst_en, input, 1 bit: enable; high in IDLE starts a transfer, low at any time aborts.
REQ-007 The block SHALL have port mode_sel, input, 2 bits: 00 single, 01 incrementing burst, 10 wrapping burst, 11 reserved (treated as single).
REQ-008 The block SHALL have port burst_len_in, input, 1 bit: serial burst length, MSB-first.
REQ-009 The block SHALL have port addr_in, input, 1 bit: serial start address, MSB-first.
REQ-010 The block SHALL have port addr_sel, output, 1 bit: mux select, high while addr_ser_out carries generated address bits.
REQ-011 The block SHALL have port addr_ser_out, output, 1 bit: serial generated address, MSB-first.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal burst completion.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, SHIFT, NEXT and DONE.
REQ-015 In IDLE with burst_en=1, the block SHALL latch mode_sel and enter LOAD on the next edge; mode_sel SHALL be ignored thereafter until the next IDLE.
REQ-016 LOAD SHALL last exactly ADDR_W cycles.
REQ-017 During LOAD, the block SHALL shift addr_in into the address register every cycle, and shift burst_len_in into the length register during the first LEN_W cycles only.
REQ-018 Beat count SHALL be 1 for single mode; otherwise it SHALL be the loaded length L, with L=0 treated as 1.
REQ-019 SHIFT SHALL last ADDR_W cycles and drive the current address MSB-first on addr_ser_out, with addr_sel=1 throughout.
REQ-020 Outside SHIFT, addr_sel SHALL be 0 and addr_ser_out SHALL be 0.
REQ-021 NEXT SHALL last one cycle, decrement the remaining-beat counter and advance the address.
REQ-022 From NEXT, the FSM SHALL return to SHIFT if beats remain, else go to DONE.
REQ-023 In incrementing mode, the next address SHALL be (addr+1) mod 2^ADDR_W; 0xFF+1 -> 0x00 at ADDR_W=8.
REQ-024 In wrapping mode, the low WRAP_LOG2 bits SHALL increment mod 2^WRAP_LOG2 and the upper bits SHALL be held.
REQ-025 Beat count in wrapping mode SHALL NOT be limited to the wrap size; addresses repeat cyclically.
REQ-026 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-027 If burst_en=1 in that IDLE cycle, a new LOAD SHALL follow, giving a one-cycle IDLE gap between bursts.
REQ-028 burst_en=0 in any non-IDLE state SHALL force IDLE on the next edge, with done not pulsed and counters cleared.
REQ-029 Latency from burst_en sampled high in IDLE to the first addr_sel=1 SHALL be ADDR_W+1 cycles.
REQ-030 Each beat SHALL occupy ADDR_W+1 cycles.

Reset
REQ-031 Asserting rst SHALL immediately force IDLE and set addr_sel, addr_ser_out, busy and done to 0.
REQ-032 Asserting rst SHALL immediately clear the address, length, bit and beat counters to 0.
REQ-033 Reset asserted mid-burst SHALL discard the burst, with no done pulse.
REQ-034 After rst deasserts, the block SHALL act on the first edge where burst_en=1.

Configuration
REQ-035 With macro BURST_WRAP_MODE_EN defined, mode_sel=10 SHALL select wrapping burst per REQ-024.
REQ-036 With BURST_WRAP_MODE_EN undefined, the wrap logic SHALL be absent and mode_sel=10 SHALL behave as incrementing burst (01).

Verification
REQ-037 Single transfer: ADDR_W=8, mode 00, addr 0xA5 -> one SHIFT frame serialising 10100101, then done pulse, busy low.
REQ-038 Incrementing burst: mode 01, addr 0x3E, len 3 -> frames 0x3E, 0x3F, 0x40; done once; 3*9 SHIFT+NEXT cycles.
REQ-039 Address wrap-around: mode 01, addr 0xFE, len 4 -> frames 0xFE, 0xFF, 0x00, 0x01.
REQ-040 Wrapping burst with macro defined: mode 10, addr 0x16, len 4, WRAP_LOG2=2 -> frames 0x16, 0x17, 0x14, 0x15; with macro undefined -> 0x16, 0x17, 0x18, 0x19.
REQ-041 Abort: burst_en dropped during beat 2 of a len-4 burst -> next cycle IDLE, addr_sel=0, busy=0, no done.
REQ-042 Reset mid-SHIFT: all outputs 0 immediately; len=0 start -> exactly one beat.
